// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with scoreboard busy bits, bypass and optional zero R0
module regfile_sb #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              read_busy1,
    output logic              read_busy2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write_en,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_reg,
    output logic              issue_ready,
    output logic              issue_err,
    output logic [ADDR_W:0]   busy_count
);
    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy, busy_nxt;
    logic              hit1, hit2, z1, z2, wr_en, iss_ok, inc, dec;

    // Combinational read ports, forwarding, issue acceptance and next busy vector
    always_comb begin
        hit1        = BYPASS != 0 && reg_write_en && write_reg == read_reg1;
        hit2        = BYPASS != 0 && reg_write_en && write_reg == read_reg2;
        z1          = ZERO_R0 != 0 && read_reg1 == '0;
        z2          = ZERO_R0 != 0 && read_reg2 == '0;
        read_data1  = z1 ? '0 : hit1 ? write_data : regs[read_reg1];
        read_data2  = z2 ? '0 : hit2 ? write_data : regs[read_reg2];
        read_busy1  = busy[read_reg1] && !hit1;
        read_busy2  = busy[read_reg2] && !hit2;
        wr_en       = reg_write_en && !(ZERO_R0 != 0 && write_reg == '0);
        issue_ready = !busy[issue_reg] || (reg_write_en && write_reg == issue_reg);
        iss_ok      = issue_en && issue_ready && !(ZERO_R0 != 0 && issue_reg == '0);
        inc         = iss_ok && !busy[issue_reg];
        dec         = wr_en && busy[write_reg] && !(iss_ok && issue_reg == write_reg);
        busy_nxt    = busy;
        if (wr_en)  busy_nxt[write_reg] = 1'b0;
        if (iss_ok) busy_nxt[issue_reg] = 1'b1;
    end

    // Register array, scoreboard, busy counter and sticky issue error
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            busy       <= '0;
            busy_count <= '0;
            issue_err  <= 1'b0;
        end else begin
            if (wr_en) regs[write_reg] <= write_data;
            busy       <= busy_nxt;
            busy_count <= busy_count + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
            if (issue_en && !issue_ready) issue_err <= 1'b1;
        end
    end
endmodule
